// File: rtl/fifo_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_frame_packer
//  Purpose  : Read-side consumer of a first-word-fall-through byte FIFO.
//             Pops bytes, groups them into frames of FRAME_LEN data bytes,
//             appends an XOR checksum byte, and presents the result as a
//             registered valid/ready stream (o_last marks the checksum).
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_frame_packer #(
    parameter int                DATA_W    = 8,
    parameter int                FRAME_LEN = 4,
    parameter logic [DATA_W-1:0] CSUM_INIT = '0,
    parameter int                CNT_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_buf_empty,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_r_en,
    input  logic              i_ready,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic [CNT_W-1:0]  o_frame_cnt,
    output logic              o_busy
);

    // Sequencer states
    localparam logic [0:0] S_DATA = 1'b0;
    localparam logic [0:0] S_CSUM = 1'b1;

    // Byte index of the final data byte in a frame (FRAME_LEN is 1..255)
    localparam logic [7:0] c_LAST_IDX = 8'(FRAME_LEN - 1);

    logic [0:0]        r_state;
    logic [7:0]        r_count;
    logic [DATA_W-1:0] r_csum;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [CNT_W-1:0]  r_frame_cnt;

    logic              w_slot_free;
    logic              w_pop;

    // The output register may be (re)loaded when empty or being drained now.
    // Popping is suppressed under reset and flush so no byte is ever lost
    // to an aborted sequence beyond the one already in flight.
    assign w_slot_free = !r_valid || i_ready;
    assign w_pop       = !i_rst && !i_flush && (r_state == S_DATA)
                         && w_slot_free && !i_buf_empty;

    // Frame sequencer, checksum accumulator and registered output stage
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_DATA;
            r_count     <= '0;
            r_csum      <= CSUM_INIT;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_frame_cnt <= '0;
        end else if (i_flush) begin
            // Abort the frame; a word still waiting downstream stays put
            // until accepted and is simply not followed by a checksum.
            r_state <= S_DATA;
            r_count <= '0;
            r_csum  <= CSUM_INIT;
            if (w_slot_free) begin
                r_valid <= 1'b0;
            end
        end else if (r_state == S_DATA) begin
            if (w_pop) begin
                r_data  <= i_rdata;
                r_last  <= 1'b0;
                r_valid <= 1'b1;
                r_csum  <= r_csum ^ i_rdata;
                if (r_count == c_LAST_IDX) begin
                    r_state <= S_CSUM;
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 8'd1;
                end
            end else if (w_slot_free) begin
                // FIFO ran dry: insert a bubble, keep count and checksum
                r_valid <= 1'b0;
            end
        end else begin
            // S_CSUM: checksum already covers every byte of the frame
            if (w_slot_free) begin
                r_data      <= r_csum;
                r_last      <= 1'b1;
                r_valid     <= 1'b1;
                r_csum      <= CSUM_INIT;
                r_frame_cnt <= r_frame_cnt + 1'b1;
                r_state     <= S_DATA;
            end
        end
    end

    assign o_r_en      = w_pop;
    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_last      = r_last;
    assign o_frame_cnt = r_frame_cnt;
    assign o_busy      = (r_count != 8'd0) || (r_state == S_CSUM);

endmodule
`default_nettype wire

// File: tb/tb_fifo_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_frame_packer
//  Purpose  : Self-checking bench for fifo_frame_packer (FRAME_LEN=4,
//             DATA_W=8, CNT_W=8, CSUM_INIT=0). A behavioural FWFT FIFO feeds
//             the DUT; accepted output beats are logged and compared against
//             hand-computed frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_frame_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       buf_empty;
    logic [7:0] rdata;
    logic       r_en;
    logic       ready;
    logic       flush;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [7:0] frame_cnt;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    fifo_frame_packer #(
        .DATA_W    (8),
        .FRAME_LEN (4),
        .CSUM_INIT (8'h00),
        .CNT_W     (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_buf_empty (buf_empty),
        .i_rdata     (rdata),
        .o_r_en      (r_en),
        .i_ready     (ready),
        .i_flush     (flush),
        .o_valid     (valid),
        .o_data      (data),
        .o_last      (last),
        .o_frame_cnt (frame_cnt),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural FWFT FIFO: pushes from the stimulus, pops on r_en edges
    logic [7:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign buf_empty = (wr_ptr == rd_ptr);
    assign rdata     = fifo_mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (r_en) rd_ptr <= rd_ptr + 1;
    end

    // Beat logger: records every handshake, flags pops from an empty FIFO
    logic [7:0] log_data [0:4095];
    logic       log_last [0:4095];
    int n_beats   = 0;
    int bad_pops  = 0;

    always @(negedge clk) begin
        if (valid && ready) begin
            log_data[n_beats[11:0]] = data;
            log_last[n_beats[11:0]] = last;
            n_beats = n_beats + 1;
        end
        if (r_en && buf_empty) bad_pops = bad_pops + 1;
    end

    typedef struct {
        string      name;
        logic [31:0] din;    // byte 0 in bits [31:24]
        logic [7:0]  csum;   // hand-computed XOR of the four bytes
        int          stall;  // cycles of i_ready=0 on the first beat
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push4(input logic [31:0] din);
        for (int i = 0; i < 4; i++) push(din[31-8*i -: 8]);
    endtask

    task automatic wait_beats(input int target, input string name);
        int guard;
        guard = 0;
        while (n_beats < target && guard < 200) begin
            tick();
            guard++;
        end
        if (n_beats < target) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s_timeout: got %0d beats, expected %0d", name, n_beats, target);
        end
    endtask

    task automatic check_frame(input int start, input logic [31:0] din,
                               input logic [7:0] csum, input string name);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_d%0d", name, i), 32'(log_data[(start+i) % 4096]), 32'(din[31-8*i -: 8]));
            check($sformatf("%s_l%0d", name, i), 32'(log_last[(start+i) % 4096]), 32'd0);
        end
        check($sformatf("%s_csum", name), 32'(log_data[(start+4) % 4096]), 32'(csum));
        check($sformatf("%s_lastc", name), 32'(log_last[(start+4) % 4096]), 32'd1);
    endtask

    task automatic run_frame(input string name, input logic [31:0] din,
                             input logic [7:0] csum, input int stall);
        int start, cnt0, pops0, guard;
        logic [7:0] held;
        start = n_beats;
        cnt0  = int'(frame_cnt);
        pops0 = rd_ptr;
        ready = 1'b1;
        push4(din);
        if (stall > 0) begin
            guard = 0;
            while (!valid && guard < 50) begin
                tick();
                guard++;
            end
            ready = 1'b0;
            held  = data;
            check({name, "_first"}, 32'(held), 32'(din[31:24]));
            for (int s = 0; s < stall; s++) begin
                tick();
                check({name, "_hold_v"}, 32'(valid), 32'd1);
                check({name, "_hold_d"}, 32'(data), 32'(held));
                check({name, "_hold_ren"}, 32'(r_en), 32'd0);
            end
            ready = 1'b1;
        end
        wait_beats(start + 5, name);
        check_frame(start, din, csum, name);
        check({name, "_cnt"}, 32'(frame_cnt), 32'((cnt0 + 1) % 256));
        check({name, "_pops"}, 32'(rd_ptr - pops0), 32'd4);
    endtask

    initial begin : main
        int start;

        vecs[0] = '{"basic",  32'h01020304, 8'h04, 0};
        vecs[1] = '{"bp_lo",  32'h10111213, 8'h00, 5};
        vecs[2] = '{"bp_hi",  32'h14151617, 8'h00, 0};
        vecs[3] = '{"mix_a",  32'hA55A0F01, 8'hF1, 2};
        vecs[4] = '{"mix_b",  32'h80402012, 8'hF2, 0};
        vecs[5] = '{"ones",   32'hFFFFFFFE, 8'h01, 1};

        rst   = 1'b1;
        ready = 1'b0;
        flush = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data",  32'(data),  32'd0);
        check("rst_last",  32'(last),  32'd0);
        check("rst_cnt",   32'(frame_cnt), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_ren",   32'(r_en),  32'd0);
        rst = 1'b0;
        tick();

        // Table-driven frames, including backpressure stalls on the first beat
        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].name, vecs[v].din, vecs[v].csum, vecs[v].stall);
            repeat (2) tick();
        end

        // FIFO empty mid-frame: bubble while waiting, state preserved
        start = n_beats;
        ready = 1'b1;
        push(8'hA0);
        push(8'hA1);
        repeat (3) tick();
        for (int g = 0; g < 10; g++) begin
            check("gap_valid", 32'(valid), 32'd0);
            check("gap_busy",  32'(busy),  32'd1);
            tick();
        end
        push(8'hA2);
        push(8'hA3);
        wait_beats(start + 5, "gap");
        check_frame(start, 32'hA0A1A2A3, 8'h00, "gap");

        // Flush with the second byte still pending downstream
        repeat (2) tick();
        start = n_beats;
        push(8'h55);
        push(8'h66);
        wait_beats(start + 1, "flush_pre");
        ready = 1'b0;
        flush = 1'b1;
        check("flush_busy_pre", 32'(busy), 32'd1);
        check("flush_ren",      32'(r_en), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_hold_v", 32'(valid), 32'd1);
        check("flush_hold_d", 32'(data),  32'h66);
        check("flush_busy",   32'(busy),  32'd0);
        ready = 1'b1;
        tick();
        check("flush_drop_v", 32'(valid), 32'd0);
        repeat (3) tick();
        check("flush_no_csum", 32'(n_beats - start), 32'd2);
        check("flush_66", 32'(log_data[(start+1) % 4096]), 32'h66);
        run_frame("post_flush", 32'h01020304, 8'h04, 0);

        // Reset in the middle of a frame while the third byte is stalled
        repeat (2) tick();
        start = n_beats;
        push4(32'hC0C1C2C3);
        push(8'hC4);
        push(8'hC5);
        push(8'hC6);
        wait_beats(start + 2, "rst_mid_pre");
        ready = 1'b0;
        check("rst_mid_third", 32'(data), 32'hC2);
        rst = 1'b1;
        tick();
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_last",  32'(last),  32'd0);
        check("rst_mid_cnt",   32'(frame_cnt), 32'd0);
        check("rst_mid_busy",  32'(busy),  32'd0);
        ready = 1'b1;
        #1;
        check("rst_mid_ren",   32'(r_en),  32'd0);
        tick();
        rst = 1'b0;
        wait_beats(start + 7, "rst_mid");
        check_frame(start + 2, 32'hC3C4C5C6, 8'h04, "rst_mid");
        check("rst_mid_cnt1", 32'(frame_cnt), 32'd1);

        // Counter wrap: 256 frames from reset, one byte = f, three zeros
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = 0; f < 256; f++) begin
            start = n_beats;
            push4({8'(f), 24'h000000});
            wait_beats(start + 5, "wrap");
            if (f == 254) check("wrap_cnt255", 32'(frame_cnt), 32'd255);
        end
        check("wrap_csum", 32'(log_data[(n_beats-1) % 4096]), 32'hFF);
        check("wrap_cnt0", 32'(frame_cnt), 32'd0);

        check("no_pop_when_empty", 32'(bad_pops), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
